// File: rtl/hash_result_writer_if.sv
// Bundles the result-writer signals: the batch hand-off from the parallel
// hasher, the memory write port, and the status outputs.
// The master modport is the side that supplies results and consumes writes.
interface hash_result_writer_if #(
    parameter int N = 7
);
    logic        results_valid;
    logic [31:0] answer [0:N];
    logic [15:0] output_addr;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        busy;
    logic        done;
    logic        overrun;
    logic [31:0] min_hash;
    logic [7:0]  min_index;

    modport master (
        output results_valid, answer, output_addr,
        input  mem_we, mem_addr, mem_write_data, busy, done, overrun,
        input  min_hash, min_index
    );

    modport slave (
        input  results_valid, answer, output_addr,
        output mem_we, mem_addr, mem_write_data, busy, done, overrun,
        output min_hash, min_index
    );
endinterface

// File: rtl/hash_result_writer.sv
// hash_result_writer: captures a batch of N+1 hash words and writes them
// to consecutive memory addresses, one word per cycle, then pulses done.
// A results_valid that arrives while a batch is in flight is dropped and
// flagged on the sticky overrun output.
// Optional feature: define HASH_MIN_TRACK_EN to track the smallest word
// (and its index) of each batch; otherwise min_hash/min_index read as 0.
// All outputs are registered; they are loaded from next-state values so
// that they line up with the state they describe.
module hash_result_writer #(
    parameter int N = 7
) (
    input  logic               clk,
    input  logic               reset_n,
    hash_result_writer_if.slave bus
);

    localparam int             IW       = (N < 2) ? 1 : $clog2(N + 1);
    localparam logic [IW-1:0]  LAST_IDX = IW'(N);
    localparam logic [IW-1:0]  IDX_ONE  = IW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic [IW-1:0]  idx_r;
    logic [IW-1:0]  idx_nxt_s;
    logic [15:0]    base_r;
    logic [15:0]    base_nxt_s;
    logic [31:0]    buf_r [0:N];
    logic           capture_s;
    logic           overrun_set_s;
    logic [15:0]    wr_addr_nxt_s;
    logic [31:0]    wr_data_nxt_s;

    logic           mem_we_r;
    logic [15:0]    mem_addr_r;
    logic [31:0]    mem_write_data_r;
    logic           busy_r;
    logic           done_r;
    logic           overrun_r;

    // Next-state, index and capture decisions for the batch FSM.
    always_comb begin
        state_nxt_s   = state_r;
        idx_nxt_s     = idx_r;
        base_nxt_s    = base_r;
        capture_s     = 1'b0;
        overrun_set_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.results_valid) begin
                    capture_s   = 1'b1;
                    state_nxt_s = WRITE;
                    idx_nxt_s   = '0;
                    base_nxt_s  = bus.output_addr;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WRITE: begin
                overrun_set_s = bus.results_valid;
                if (idx_r == LAST_IDX) begin
                    state_nxt_s = FINISH;
                end else begin
                    idx_nxt_s = idx_r + IDX_ONE;
                end
            end
            FINISH: begin
                overrun_set_s = bus.results_valid;
                state_nxt_s   = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Address/data for the next cycle; on capture the live inputs are used
    // because the buffer is being loaded on the same edge.
    always_comb begin
        wr_addr_nxt_s = base_nxt_s + 16'(idx_nxt_s);
        if (capture_s) begin
            wr_data_nxt_s = bus.answer[0];
        end else begin
            wr_data_nxt_s = buf_r[idx_nxt_s];
        end
    end

    // FSM state, index, base address and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r          <= IDLE;
            idx_r            <= '0;
            base_r           <= 16'h0000;
            mem_we_r         <= 1'b0;
            mem_addr_r       <= 16'h0000;
            mem_write_data_r <= 32'h0000_0000;
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
            overrun_r        <= 1'b0;
        end else begin
            state_r          <= state_nxt_s;
            idx_r            <= idx_nxt_s;
            base_r           <= base_nxt_s;
            mem_we_r         <= (state_nxt_s == WRITE);
            mem_addr_r       <= wr_addr_nxt_s;
            mem_write_data_r <= wr_data_nxt_s;
            busy_r           <= (state_nxt_s != IDLE);
            done_r           <= (state_nxt_s == FINISH);
            if (capture_s) begin
                overrun_r <= 1'b0;
            end else if (overrun_set_s) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    // Answer buffer: loaded once per accepted batch, held until the next one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= N; i++) begin
                buf_r[i] <= 32'h0000_0000;
            end
        end else if (capture_s) begin
            for (int i = 0; i <= N; i++) begin
                buf_r[i] <= bus.answer[i];
            end
        end
    end

    assign bus.mem_we         = mem_we_r;
    assign bus.mem_addr       = mem_addr_r;
    assign bus.mem_write_data = mem_write_data_r;
    assign bus.busy           = busy_r;
    assign bus.done           = done_r;
    assign bus.overrun        = overrun_r;

`ifdef HASH_MIN_TRACK_EN
    logic [31:0] run_min_r;
    logic [7:0]  run_idx_r;
    logic [31:0] min_hash_r;
    logic [7:0]  min_index_r;
    logic        cand_take_s;
    logic [31:0] cand_min_s;
    logic [7:0]  cand_idx_s;

    // Running minimum including the word being written this cycle; strict
    // less-than keeps the earlier index on ties.
    always_comb begin
        cand_take_s = (idx_r == '0) || (buf_r[idx_r] < run_min_r);
        if (cand_take_s) begin
            cand_min_s = buf_r[idx_r];
            cand_idx_s = 8'(idx_r);
        end else begin
            cand_min_s = run_min_r;
            cand_idx_s = run_idx_r;
        end
    end

    // Track the minimum while writing; publish it on the last write so it
    // is valid from the done cycle onwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_min_r   <= 32'h0000_0000;
            run_idx_r   <= 8'h00;
            min_hash_r  <= 32'h0000_0000;
            min_index_r <= 8'h00;
        end else if (state_r == WRITE) begin
            run_min_r <= cand_min_s;
            run_idx_r <= cand_idx_s;
            if (idx_r == LAST_IDX) begin
                min_hash_r  <= cand_min_s;
                min_index_r <= cand_idx_s;
            end
        end
    end

    assign bus.min_hash  = min_hash_r;
    assign bus.min_index = min_index_r;
`else
    assign bus.min_hash  = 32'h0000_0000;
    assign bus.min_index = 8'h00;
`endif

endmodule

// File: tb/tb_hash_result_writer.sv
// Self-checking bench for hash_result_writer (N = 7): table-driven batches,
// hand-written overrun / back-to-back / mid-batch reset sequences, and
// randomized batches checked against a simple reference model.
module tb_hash_result_writer;

    localparam int N = 7;

`ifdef HASH_MIN_TRACK_EN
    localparam bit MIN_EN = 1'b1;
`else
    localparam bit MIN_EN = 1'b0;
`endif

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_fail;

    hash_result_writer_if #(.N(N)) bus ();

    hash_result_writer #(.N(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]      base;
        logic [7:0][31:0] ans;
        logic [15:0]      last_addr;
        logic [31:0]      min_h;
        logic [7:0]       min_i;
    } vec_t;

    vec_t vecs [0:3];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: smallest word, earliest index on ties.
    task automatic ref_min(input logic [7:0][31:0] a, output logic [31:0] m, output logic [7:0] mi);
        m  = a[0];
        mi = 8'd0;
        for (int i = 1; i <= N; i++) begin
            if (a[i] < m) begin
                m  = a[i];
                mi = 8'(i);
            end
        end
    endtask

    task automatic scramble_inputs();
        bus.output_addr = 16'($urandom);
        for (int i = 0; i <= N; i++) bus.answer[i] = $urandom;
    endtask

    // Must be called in an IDLE cycle, #1 after an edge. Returns #1 after
    // the edge into the IDLE cycle following FINISH.
    task automatic run_batch(input string tag, input logic [15:0] base,
                             input logic [7:0][31:0] ans, input int pulse_at,
                             input logic [15:0] exp_last, input logic [31:0] exp_min,
                             input logic [7:0] exp_idx, output int n_wr);
        logic [15:0] last_seen;
        last_seen = 16'h0000;
        n_wr = 0;
        bus.output_addr = base;
        for (int i = 0; i <= N; i++) bus.answer[i] = ans[i];
        bus.results_valid = 1'b1;
        tick();
        for (int c = 1; c <= N + 2; c++) begin
            bus.results_valid = (c == pulse_at);
            scramble_inputs();
            if (bus.mem_we) n_wr++;
            if (c <= N + 1) begin
                chk($sformatf("%s we c%0d", tag, c), bus.mem_we, 1'b1);
                chk($sformatf("%s addr c%0d", tag, c), bus.mem_addr, 16'(base + 16'(c - 1)));
                chk($sformatf("%s data c%0d", tag, c), bus.mem_write_data, ans[c - 1]);
                chk($sformatf("%s busy/done c%0d", tag, c), {bus.busy, bus.done}, 2'b10);
                last_seen = bus.mem_addr;
                if (c == 1) chk($sformatf("%s ovr_clear", tag), bus.overrun, 1'b0);
            end else begin
                chk($sformatf("%s fin we/busy/done", tag), {bus.mem_we, bus.busy, bus.done}, 3'b011);
                chk($sformatf("%s last_addr", tag), last_seen, exp_last);
                chk($sformatf("%s min_hash", tag), bus.min_hash, MIN_EN ? exp_min : 32'h0);
                chk($sformatf("%s min_index", tag), bus.min_index, MIN_EN ? exp_idx : 8'h0);
            end
            tick();
        end
        bus.results_valid = 1'b0;
        if (bus.mem_we) n_wr++;
        chk($sformatf("%s idle we/busy/done", tag), {bus.mem_we, bus.busy, bus.done}, 3'b000);
        chk($sformatf("%s overrun", tag), bus.overrun, (pulse_at != 0));
        chk($sformatf("%s nwrites", tag), n_wr, N + 1);
        chk($sformatf("%s min_hold", tag), bus.min_hash, MIN_EN ? exp_min : 32'h0);
    endtask

    initial begin
        int          nw;
        int          nw2;
        int          bad;
        logic [7:0][31:0] ra;
        logic [15:0] rb;
        logic [31:0] rm;
        logic [7:0]  ri;
        int          rp;

        n_cmp  = 0;
        n_fail = 0;

        // Stimulus table.
        vecs[0].base = 16'h0100; vecs[0].last_addr = 16'h0107;
        vecs[0].min_h = 32'h1000; vecs[0].min_i = 8'd0;
        for (int i = 0; i <= N; i++) vecs[0].ans[i] = 32'h1000 + 32'(i);
        vecs[1].base = 16'h0200; vecs[1].last_addr = 16'h0207;
        vecs[1].min_h = 32'd5; vecs[1].min_i = 8'd1;
        vecs[1].ans[0] = 32'd9; vecs[1].ans[1] = 32'd5; vecs[1].ans[2] = 32'd7; vecs[1].ans[3] = 32'd5;
        vecs[1].ans[4] = 32'd8; vecs[1].ans[5] = 32'd6; vecs[1].ans[6] = 32'd9; vecs[1].ans[7] = 32'd9;
        vecs[2].base = 16'hFFFE; vecs[2].last_addr = 16'h0005;
        vecs[2].min_h = 32'hFFFF_FFE9; vecs[2].min_i = 8'd7;
        for (int i = 0; i <= N; i++) vecs[2].ans[i] = 32'hFFFF_FFF0 - 32'(i);
        vecs[3].base = 16'h1234; vecs[3].last_addr = 16'h123B;
        vecs[3].min_h = 32'hA5A5_A5A5; vecs[3].min_i = 8'd0;
        for (int i = 0; i <= N; i++) vecs[3].ans[i] = 32'hA5A5_A5A5;

        // Reset.
        reset_n = 1'b0;
        bus.results_valid = 1'b0;
        scramble_inputs();
        tick(); tick();
        chk("reset outs", {bus.mem_we, bus.busy, bus.done, bus.overrun}, 4'b0000);
        chk("reset min", {bus.min_hash, bus.min_index}, 40'h0);
        reset_n = 1'b1;
        tick(); tick();
        chk("post-reset idle", {bus.mem_we, bus.busy, bus.done, bus.overrun}, 4'b0000);

        // Table-driven batches.
        for (int v = 0; v < 4; v++) begin
            run_batch($sformatf("vec%0d", v), vecs[v].base, vecs[v].ans, 0,
                      vecs[v].last_addr, vecs[v].min_h, vecs[v].min_i, nw);
            tick(); tick();
        end

        // Overrun: second valid 3 cycles after the first, then a clean batch.
        run_batch("ovr", vecs[0].base, vecs[0].ans, 3, vecs[0].last_addr,
                  vecs[0].min_h, vecs[0].min_i, nw);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (bus.mem_we || bus.busy) bad++;
            tick();
        end
        chk("ovr dropped batch idle", bad, 0);
        run_batch("ovr_next", vecs[1].base, vecs[1].ans, 0, vecs[1].last_addr,
                  vecs[1].min_h, vecs[1].min_i, nw);
        tick();

        // Back-to-back: second valid in the IDLE cycle right after FINISH.
        run_batch("b2b_a", vecs[2].base, vecs[2].ans, 0, vecs[2].last_addr,
                  vecs[2].min_h, vecs[2].min_i, nw);
        run_batch("b2b_b", vecs[3].base, vecs[3].ans, 0, vecs[3].last_addr,
                  vecs[3].min_h, vecs[3].min_i, nw2);
        chk("b2b total writes", nw + nw2, 16);
        tick();

        // Reset after the 4th write of a batch (with an overrun pending).
        bus.output_addr = 16'h0400;
        for (int i = 0; i <= N; i++) bus.answer[i] = 32'h2000 + 32'(i);
        bus.results_valid = 1'b1;
        tick();
        bus.results_valid = 1'b0;
        tick();
        bus.results_valid = 1'b1;
        tick();
        bus.results_valid = 1'b0;
        tick();
        chk("rst_pre 4th write", {bus.mem_we, bus.mem_addr, bus.mem_write_data}, {1'b1, 16'h0403, 32'h2003});
        chk("rst_pre overrun", bus.overrun, 1'b1);
        tick();
        reset_n = 1'b0;
        #1;
        chk("rst_mid outs", {bus.mem_we, bus.busy, bus.done, bus.overrun}, 4'b0000);
        tick(); tick();
        reset_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.mem_we || bus.done || bus.busy) bad++;
            tick();
        end
        chk("rst_mid no resume", bad, 0);
        run_batch("after_rst", vecs[0].base, vecs[0].ans, 0, vecs[0].last_addr,
                  vecs[0].min_h, vecs[0].min_i, nw);

        // Randomized batches against the reference model.
        for (int r = 0; r < 10; r++) begin
            if ($urandom_range(0, 3) == 0) rb = 16'hFFF8 + 16'($urandom_range(0, 7));
            else rb = 16'($urandom);
            for (int i = 0; i <= N; i++) begin
                if (r % 2 == 0) ra[i] = 32'($urandom_range(0, 3));
                else ra[i] = $urandom;
            end
            rp = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, N + 2));
            ref_min(ra, rm, ri);
            run_batch($sformatf("rnd%0d", r), rb, ra, rp, 16'(rb + 16'd7), rm, ri, nw);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hash_result_writer.md
HASH_RESULT_WRITER -- requirements
Module: hash_result_writer

Interface
REQ-001 SHALL have parameter N, default 7, meaning highest answer index; answer array is [0:N] and 1 <= N <= 255.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port results_valid, input, 1 bit: one-cycle pulse from the parallel hasher's done.
REQ-005 SHALL have port answer[0:N], input, 32 bits each: final h0 word per nonce index.
REQ-006 SHALL have port output_addr, input, 16 bits: memory base address for the result block.
REQ-007 SHALL have port mem_we, output, 1 bit: memory write strobe.
REQ-008 SHALL have port mem_addr, output, 16 bits: memory write address.
REQ-009 SHALL have port mem_write_data, output, 32 bits: memory write data.
REQ-010 SHALL have port busy, output, 1 bit: high in WRITE and FINISH.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port overrun, output, 1 bit: sticky flag for results_valid dropped while busy.
REQ-013 SHALL have port min_hash, output, 32 bits: smallest answer of the last batch.
REQ-014 SHALL have port min_index, output, 8 bits: nonce index of min_hash.

Function
REQ-015 SHALL implement states IDLE, WRITE, FINISH; IDLE->WRITE on results_valid, WRITE->FINISH after index N written, FINISH->IDLE unconditionally.
REQ-016 SHALL, on the edge sampling results_valid in IDLE, capture all answer words and output_addr into internal buffers, and clear index to 0 and overrun to 0.
REQ-017 SHALL, in WRITE, drive mem_we=1, mem_addr=captured base+index (mod 2^16), mem_write_data=buffer[index], and increment index by 1 per cycle.
REQ-018 SHALL write exactly N+1 words, one per cycle, in ascending index order, with no gaps.
REQ-019 SHALL hold mem_we=0 in IDLE and FINISH; mem_addr and mem_write_data are don't-care when mem_we=0.
REQ-020 SHALL assert done for exactly one cycle in FINISH, i.e. N+2 cycles after the capturing edge.
REQ-021 SHALL ignore answer and output_addr changes after capture; buffered values are used for the whole batch.
REQ-022 SHALL, when results_valid is high in WRITE or FINISH, drop that batch and set overrun, which holds until the next accepted capture.
REQ-023 SHALL accept results_valid sampled in the IDLE cycle immediately following FINISH (back-to-back batches).
REQ-024 SHALL compute the 16-bit address sum with wrap-around: base 16'hFFFF, index 1 yields 16'h0000.

Reset
REQ-025 SHALL, on reset_n low, asynchronously force state IDLE, mem_we=0, busy=0, done=0, overrun=0, min_hash=32'h0, min_index=8'h0, index=0.
REQ-026 SHALL abort a batch in progress on reset, write no further words, and require a new results_valid after release.

Configuration
REQ-027 SHALL compile min tracking in only when macro HASH_MIN_TRACK_EN is defined.
REQ-028 SHALL, with HASH_MIN_TRACK_EN defined, compare each word as written using an unsigned compare, keep the lower index on ties, and present the final min_hash and min_index stable from the done cycle until the next capture.
REQ-029 SHALL, without HASH_MIN_TRACK_EN, tie min_hash and min_index to 0 and contain no compare logic.

Verification
REQ-030 SHALL verify basic batch with N=7, output_addr=16'h0100, answer[i]=32'h1000+i, pulse valid -> 8 writes to addr 0x0100..0x0107 with data 0x1000..0x1007 on consecutive cycles, and done exactly 9 cycles after the capture edge.
REQ-031 SHALL verify min tracking with HASH_MIN_TRACK_EN, answers {9,5,7,5,8,6,9,9} -> min_hash=5, min_index=1 at done; without the macro -> both 0.
REQ-032 SHALL verify address wrap with output_addr=16'hFFFE -> writes land at 0xFFFE, 0xFFFF, 0x0000, ... 0x0005.
REQ-033 SHALL verify overrun with a second results_valid 3 cycles after the first -> second batch is not written, overrun=1, first batch completes intact, and the next accepted capture clears overrun.
REQ-034 SHALL verify reset mid-WRITE with reset_n low after the 4th write -> mem_we=0 immediately, busy=0, no done pulse, and a later batch behaves per REQ-030.
REQ-035 SHALL verify back-to-back batches with valid pulsed in the IDLE cycle right after FINISH -> second batch is accepted, overrun=0, and 16 total writes occur.
